// File: rtl/regfile_dump_reader_if.sv
// regfile_dump_reader_if: valid/ready word stream from the dump reader toward the debug/host link.
interface regfile_dump_reader_if #(
    parameter int DATA_W = 32
);
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: on start, streams a header word then x0..x(NUM_REGS-1) read through a spare
// register-file read port. Define CHECKSUM_EN to append an XOR trailer word after the last register.
module regfile_dump_reader #(
    parameter int                NUM_REGS   = 32,
    parameter int                ADDR_W     = 5,
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] HEADER_TAG = 32'hC0DE_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_W-1:0]     RdAddr,
    input  logic [DATA_W-1:0]     RdData,
    regfile_dump_reader_if.master m,
    output logic                  busy,
    output logic                  done
);

`ifdef CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_READ, S_SEND, S_TRAILER, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_READ, S_SEND, S_DONE} state_t;
`endif

    localparam logic [ADDR_W:0]   LAST_IDX    = (ADDR_W+1)'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   IDX_ONE     = (ADDR_W+1)'(1);
    localparam logic [DATA_W-1:0] HEADER_WORD = HEADER_TAG | DATA_W'(NUM_REGS);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     idx_q;
    logic [DATA_W-1:0]   data_q;
    logic                xfer;
    logic                last_idx;
`ifdef CHECKSUM_EN
    logic [DATA_W-1:0]   csum_q;
`endif

    assign last_idx = (idx_q == LAST_IDX);
    assign xfer     = m.m_valid & m.m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_HEADER;
            S_HEADER: if (xfer)  state_d = S_READ;
            S_READ:   state_d = S_SEND;
            S_SEND: begin
                if (xfer) begin
                    if (last_idx)
`ifdef CHECKSUM_EN
                        state_d = S_TRAILER;
`else
                        state_d = S_DONE;
`endif
                    else
                        state_d = S_READ;
                end
            end
`ifdef CHECKSUM_EN
            S_TRAILER: if (xfer) state_d = S_DONE;
`endif
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // abort beats any transfer on the same edge; start wins in IDLE since abort is ignored there
        if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
    end

    // Word register: header on start, register value in READ, checksum after the last SEND
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            data_q <= '0;
`ifdef CHECKSUM_EN
            csum_q <= '0;
`endif
        end else if (state_d == S_IDLE) begin
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: data_q <= HEADER_WORD;
                S_HEADER: begin
                    idx_q  <= '0;
`ifdef CHECKSUM_EN
                    csum_q <= '0;
`endif
                end
                // x0 is hardwired zero regardless of what the port returns
                S_READ: data_q <= (idx_q == '0) ? '0 : RdData;
                S_SEND: begin
                    if (xfer) begin
`ifdef CHECKSUM_EN
                        csum_q <= csum_q ^ data_q;
                        if (last_idx) data_q <= csum_q ^ data_q;
`endif
                        if (!last_idx) idx_q <= idx_q + IDX_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m.m_data  = data_q;
`ifdef CHECKSUM_EN
    assign m.m_valid = (state_q == S_HEADER) || (state_q == S_SEND) || (state_q == S_TRAILER);
    assign m.m_last  = (state_q == S_TRAILER);
`else
    assign m.m_valid = (state_q == S_HEADER) || (state_q == S_SEND);
    assign m.m_last  = (state_q == S_SEND) && last_idx;
`endif
    assign RdAddr = ((state_q == S_READ) || (state_q == S_SEND)) ? idx_q[ADDR_W-1:0] : '0;
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: drives dumps against a register-file array and compares each frame with a
// model frame built from the register contents.
module tb_regfile_dump_reader;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam logic [31:0] HDR = 32'hC0DE0020;
`ifdef CHECKSUM_EN
    localparam int FRAME = NUM_REGS + 2;
    localparam int SPAN  = 2 + 2 * NUM_REGS;
`else
    localparam int FRAME = NUM_REGS + 1;
    localparam int SPAN  = 1 + 2 * NUM_REGS;
`endif

    logic clk = 0;
    logic rst_n = 1;
    logic start = 0;
    logic abort = 0;
    logic [ADDR_W-1:0] RdAddr;
    logic [DATA_W-1:0] RdData;
    logic busy, done;
    logic [31:0] regs [NUM_REGS];

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q [$];
    logic [31:0] got_data [$];
    logic        got_last [$];
    int          got_cyc [$];
    logic [31:0] stall_data [$];
    logic [4:0]  stall_addr [$];
    int first_valid, done_cyc;
    bit timed_out;
    logic done_after, busy_after, busy_at_done;

    regfile_dump_reader_if #(.DATA_W(DATA_W)) s();

    regfile_dump_reader #(
        .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HEADER_TAG(32'hC0DE_0000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .RdAddr(RdAddr), .RdData(RdData), .m(s), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    assign RdData = regs[RdAddr];

    function automatic void build_exp();
        logic [31:0] x;
        x = '0;
        exp_q.delete();
        exp_q.push_back(HDR);
        for (int i = 0; i < NUM_REGS; i++) begin
            exp_q.push_back((i == 0) ? 32'h0 : regs[i]);
            x = x ^ ((i == 0) ? 32'h0 : regs[i]);
        end
`ifdef CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endfunction

    task automatic set_plan_regs();
        for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;
        regs[2] = 32'd1024; regs[5] = 32'd123; regs[10] = 32'd999;
    endtask

    // rmode 0: always ready, 1: random ready, 2: stall 3 cycles on x5
    task automatic collect_frame(input int rmode, input int restart_cyc);
        int cyc, stalls;
        bit fin;
        got_data.delete(); got_last.delete(); got_cyc.delete();
        stall_data.delete(); stall_addr.delete();
        first_valid = -1; done_cyc = -1; timed_out = 0;
        cyc = 0; stalls = 0; fin = 0;
        @(negedge clk); start = 1; abort = 0;
        while (!fin) begin
            @(negedge clk);
            start = (cyc == restart_cyc);
            if (done) begin
                done_cyc = cyc; busy_at_done = busy; fin = 1;
            end else begin
                if (rmode == 1) s.m_ready = ($urandom_range(0, 3) != 0);
                else if (rmode == 2 && s.m_valid && RdAddr == 5 && stalls < 3) begin
                    s.m_ready = 0; stalls++;
                    stall_data.push_back(s.m_data); stall_addr.push_back(RdAddr);
                end else s.m_ready = 1;
                if (s.m_valid) begin
                    if (first_valid < 0) first_valid = cyc;
                    if (s.m_ready) begin
                        got_data.push_back(s.m_data); got_last.push_back(s.m_last); got_cyc.push_back(cyc);
                    end
                end
                cyc++;
                if (cyc > 2000) begin timed_out = 1; fin = 1; end
            end
        end
        @(negedge clk);
        start = 0;
        done_after = done; busy_after = busy;
    endtask

    task automatic test_reset();
        int n;
        #1;
        checks++;
        if ({s.m_valid, s.m_last, busy, done} !== 4'b0 || RdAddr !== '0 || s.m_data !== '0) begin
            failures++;
            $display("FAIL reset_init valid=%b last=%b busy=%b done=%b addr=%0d data=%h required all zero",
                     s.m_valid, s.m_last, busy, done, RdAddr, s.m_data);
        end
        @(negedge clk); rst_n = 1;
        set_plan_regs();
        s.m_ready = 1;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        n = 0;
        while (!(s.m_valid && RdAddr == 7) && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n >= 100) begin failures++; $display("FAIL reset_reach_idx7 cycles=%0d required <100", n); end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({s.m_valid, s.m_last, busy, done} !== 4'b0 || RdAddr !== '0 || s.m_data !== '0) begin
            failures++;
            $display("FAIL reset_mid_send valid=%b last=%b busy=%b done=%b addr=%0d data=%h required all zero",
                     s.m_valid, s.m_last, busy, done, RdAddr, s.m_data);
        end
        @(negedge clk); rst_n = 1;
        collect_frame(0, -1);
        checks++;
        if (timed_out || got_data.size() == 0 || got_data[0] !== HDR) begin
            failures++;
            $display("FAIL reset_restart_header timeout=%0d got=%h required=%h", timed_out,
                     (got_data.size() > 0) ? got_data[0] : 32'hx, HDR);
        end
    endtask

    task automatic test_full_dump();
        set_plan_regs();
        build_exp();
        collect_frame(0, -1);
        checks++;
        if (timed_out || got_data.size() != FRAME) begin
            failures++;
            $display("FAIL full_len timeout=%0d got=%0d required=%0d", timed_out, got_data.size(), FRAME);
        end
        for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_q[i] || got_last[i] !== (i == exp_q.size() - 1)) begin
                failures++;
                $display("FAIL full_word[%0d] got=%h last=%b required=%h last=%b", i, got_data[i],
                         got_last[i], exp_q[i], (i == exp_q.size() - 1));
            end
        end
        checks++;
        if (got_cyc.size() == 0 || (got_cyc[$] - first_valid + 1) != SPAN) begin
            failures++;
            $display("FAIL full_span got=%0d required=%0d",
                     (got_cyc.size() > 0) ? got_cyc[$] - first_valid + 1 : -1, SPAN);
        end
        checks++;
        if (got_cyc.size() == 0 || done_cyc != got_cyc[$] + 1 || busy_at_done !== 1'b1) begin
            failures++;
            $display("FAIL full_done_timing done_cyc=%0d busy=%b required cyc=%0d busy=1", done_cyc,
                     busy_at_done, (got_cyc.size() > 0) ? got_cyc[$] + 1 : -1);
        end
        checks++;
        if (done_after !== 1'b0 || busy_after !== 1'b0) begin
            failures++;
            $display("FAIL full_done_pulse done=%b busy=%b required 0 0", done_after, busy_after);
        end
`ifdef CHECKSUM_EN
        checks++;
        if (got_data.size() != FRAME || got_data[FRAME-1] !== 32'h79C || got_last[FRAME-2] !== 1'b0) begin
            failures++;
            $display("FAIL full_trailer got=%h last_x31=%b required=79c 0",
                     (got_data.size() > 0) ? got_data[$] : 32'hx,
                     (got_last.size() > 1) ? got_last[got_last.size()-2] : 1'bx);
        end
`endif
    endtask

    task automatic test_backpressure();
        set_plan_regs();
        build_exp();
        collect_frame(2, -1);
        checks++;
        if (stall_data.size() != 3) begin
            failures++;
            $display("FAIL bp_stall_count got=%0d required=3", stall_data.size());
        end
        for (int i = 0; i < stall_data.size(); i++) begin
            checks++;
            if (stall_data[i] !== 32'd123 || stall_addr[i] !== 5'd5) begin
                failures++;
                $display("FAIL bp_hold[%0d] data=%0d addr=%0d required 123 5", i, stall_data[i], stall_addr[i]);
            end
        end
        checks++;
        if (timed_out || got_data.size() != FRAME) begin
            failures++;
            $display("FAIL bp_len timeout=%0d got=%0d required=%0d", timed_out, got_data.size(), FRAME);
        end
        for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL bp_word[%0d] got=%h required=%h", i, got_data[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_x0_restart();
        set_plan_regs();
        regs[0] = 32'hFFFF_FFFF;
        build_exp();
        collect_frame(0, 10);
        checks++;
        if (timed_out || got_data.size() != FRAME) begin
            failures++;
            $display("FAIL x0_len timeout=%0d got=%0d required=%0d", timed_out, got_data.size(), FRAME);
        end
        checks++;
        if (got_data.size() < 2 || got_data[1] !== 32'h0) begin
            failures++;
            $display("FAIL x0_forced got=%h required=0", (got_data.size() > 1) ? got_data[1] : 32'hx);
        end
        for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL x0_word[%0d] got=%h required=%h", i, got_data[i], exp_q[i]);
            end
        end
        checks++;
        if (busy_after !== 1'b0) begin
            failures++;
            $display("FAIL x0_no_requeue busy=%b required=0", busy_after);
        end
        regs[0] = '0;
    endtask

    task automatic test_abort();
        int n, delivered, dones;
        set_plan_regs();
        s.m_ready = 1;
        @(negedge clk); start = 1;
        n = 0; delivered = 0;
        @(negedge clk); start = 0;
        while (!(s.m_valid && RdAddr == 7) && n < 100) begin
            if (s.m_valid) delivered++;
            @(negedge clk); n++;
        end
        abort = 1;
        @(negedge clk); abort = 0;
        checks++;
        if (s.m_valid !== 1'b0 || s.m_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle valid=%b last=%b busy=%b done=%b required 0 0 0 0",
                     s.m_valid, s.m_last, busy, done);
        end
        checks++;
        if (delivered != 8) begin
            failures++;
            $display("FAIL abort_delivered got=%0d required=8", delivered);
        end
        dones = 0;
        for (int i = 0; i < 4; i++) begin @(negedge clk); if (done || busy) dones++; end
        checks++;
        if (dones != 0) begin failures++; $display("FAIL abort_no_done got=%0d required=0", dones); end
        build_exp();
        collect_frame(0, -1);
        checks++;
        if (timed_out || got_data.size() != FRAME) begin
            failures++;
            $display("FAIL abort_refresh_len timeout=%0d got=%0d required=%0d", timed_out, got_data.size(), FRAME);
        end
        for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL abort_refresh_word[%0d] got=%h required=%h", i, got_data[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_start_abort_idle();
        s.m_ready = 0;
        @(negedge clk); start = 1; abort = 1;
        @(negedge clk); start = 0; abort = 0;
        checks++;
        if (busy !== 1'b1 || s.m_valid !== 1'b1 || s.m_data !== HDR) begin
            failures++;
            $display("FAIL start_vs_abort busy=%b valid=%b data=%h required 1 1 %h", busy, s.m_valid, s.m_data, HDR);
        end
        abort = 1;
        @(negedge clk); abort = 0;
        checks++;
        if (busy !== 1'b0 || s.m_valid !== 1'b0) begin
            failures++;
            $display("FAIL header_abort busy=%b valid=%b required 0 0", busy, s.m_valid);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
            build_exp();
            collect_frame(1, -1);
            checks++;
            if (timed_out || got_data.size() != FRAME) begin
                failures++;
                $display("FAIL rand%0d_len timeout=%0d got=%0d required=%0d", r, timed_out, got_data.size(), FRAME);
            end
            for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
                checks++;
                if (got_data[i] !== exp_q[i] || got_last[i] !== (i == exp_q.size() - 1)) begin
                    failures++;
                    $display("FAIL rand%0d_word[%0d] got=%h last=%b required=%h last=%b", r, i, got_data[i],
                             got_last[i], exp_q[i], (i == exp_q.size() - 1));
                end
            end
        end
    endtask

    initial begin
        s.m_ready = 0;
        for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;
        #1 rst_n = 0;
        test_reset();
        test_full_dump();
        test_backpressure();
        test_x0_restart();
        test_abort();
        test_start_abort_idle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Debug read-out engine for the register unit. On a start pulse it walks x0..x(NUM_REGS-1) through one spare combinational read port of the register file. It streams a header word followed by every register value over a valid/ready word stream toward the debug/host link. It is the reading end of the register-file write path: it only reads and never asserts RUWr.

Parameters:
NUM_REGS, 32, number of registers dumped (2..32)
ADDR_W, 5, register address width
DATA_W, 32, register/stream word width
HEADER_TAG, 32'hC0DE_0000, header constant; the header word is HEADER_TAG | NUM_REGS

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a dump; honoured only in IDLE
abort  input  1  cancel the dump in progress
RdAddr  output  ADDR_W  address driven onto the register-file read port
RdData  input  DATA_W  combinational read data for RdAddr
m_valid  output  1  stream word valid
m_data  output  DATA_W  stream word
m_last  output  1  marks the final word of the frame
m_ready  input  1  downstream accepts the word
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (async, any time, including mid-dump):
  - state=IDLE, idx=0, RdAddr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0.
  - Frame is discarded, no done pulse.
- Transfer occurs on a rising edge with m_valid & m_ready.
- Once m_valid rises, m_data/m_last stay stable until transfer. The only exceptions are abort and reset.
- States:
  - IDLE: outputs low. start=1 -> HEADER.
  - HEADER: m_valid=1, m_data=HEADER_TAG|NUM_REGS, m_last=0. Transfer -> READ, idx=0.
  - READ: RdAddr=idx, m_valid=0. Next edge captures RdData into m_data -> SEND.
    - When idx==0, captures 0 regardless of RdData (x0 is hardwired zero).
  - SEND: m_valid=1. m_last=1 iff idx==NUM_REGS-1 (and CHECKSUM_EN is off). On transfer:
    - idx==NUM_REGS-1 -> DONE;
    - otherwise idx+1 -> READ.
  - DONE: done=1 for exactly one cycle, busy=1 -> IDLE.
- Latency:
  - start to header valid: 1 cycle.
  - With m_ready held high, each register costs 2 cycles (READ + SEND).
  - Full frame: 1 + 2*NUM_REGS cycles from header valid to last transfer; done follows 1 cycle later.
- RdAddr is held at idx in READ and SEND, and held at 0 in IDLE/HEADER/DONE.
- start while busy is ignored, with no restart and no queueing.
- abort:
  - In any busy state, abort -> IDLE on the next edge: m_valid=0, m_last=0, done not pulsed.
  - abort has priority over a transfer on the same edge; that word counts as not delivered.
  - abort and start on the same cycle in IDLE: start wins, abort is ignored.
- idx is ADDR_W+1 bits wide, so NUM_REGS=32 does not wrap before the compare.

Optional Feature:
CHECKSUM_EN
- Defined: adds state TRAILER after the last register.
  - The last register word has m_last=0.
  - TRAILER sends the XOR of all NUM_REGS data words (header excluded) with m_last=1, then -> DONE.
  - Running XOR clears in HEADER and updates on each SEND transfer.
  - Frame length is NUM_REGS+2 words.
- Undefined: no trailer state or XOR register; the frame is NUM_REGS+1 words.

Test Plan:
- Reset: rst_n=0 mid-SEND at idx=7 -> same cycle m_valid=0, busy=0, done=0, RdAddr=0. After release, start -> header 32'hC0DE0020 again.
- Full dump, m_ready=1, model x2=1024, x5=123, x10=999, others 0:
  - 33 words: 0xC0DE0020, then 0,0,1024,0,0,123,...,999 at data index 10, ..., 0.
  - m_last only on word 33; done pulses 1 cycle after it; 65 cycles from header valid to last transfer.
- Backpressure: m_ready=0 for 3 cycles while x5 is presented -> m_valid=1 and m_data=123 held all 3 cycles, RdAddr=5; dump resumes with x6 after the transfer.
- x0 forcing: model returns 32'hFFFFFFFF for address 0 -> first data word is 0. Start pulsed again mid-dump -> no effect on sequence.
- Abort: abort=1 while SEND idx=7 with m_ready=1 -> next cycle IDLE, m_valid=0, no done, word 7 not counted. Next start -> fresh header, idx restarts at 0.
- CHECKSUM_EN with the values from the full-dump scenario -> 34 words. The trailer is 1024^123^999=1948 (0x79C) with m_last=1; word 33 (x31) has m_last=0.
